// File: rtl/bcd_counter_ctrl_pkg.sv
// Shared constants and helpers for the BCD counter controller.
package bcd_counter_ctrl_pkg;

  localparam int DIGIT_W            = 4;
  localparam int REFRESH_CYCLES_DEF = 32;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  localparam bcd_digit_t DIGIT_MAX  = 4'd9;
  localparam bcd_digit_t DIGIT_ZERO = 4'd0;
  localparam bcd_digit_t DIGIT_ONE  = 4'd1;

  // Non-decimal nibbles are replaced by zero; valid digits pass through.
  function automatic bcd_digit_t sanitize_digit(input bcd_digit_t d);
    bcd_digit_t r;
    if (d > DIGIT_MAX) begin
      r = DIGIT_ZERO;
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_counter_ctrl_digit.sv
// Single BCD digit stepper: increments or decrements when carry/borrow in is set.
module bcd_digit
  import bcd_counter_ctrl_pkg::*;
(
  input  logic       [DIGIT_W-1:0] digit_i,
  input  logic                     up_i,
  input  logic                     cin_i,
  output logic       [DIGIT_W-1:0] digit_o,
  output logic                     cout_o
);

  // Next digit value and ripple carry/borrow out.
  always_comb begin
    digit_o = digit_i;
    cout_o  = 1'b0;
    if (!cin_i) begin
      digit_o = digit_i;
      cout_o  = 1'b0;
    end else if (up_i) begin
      if (digit_i >= DIGIT_MAX) begin
        digit_o = DIGIT_ZERO;
        cout_o  = 1'b1;
      end else begin
        digit_o = digit_i + DIGIT_ONE;
        cout_o  = 1'b0;
      end
    end else begin
      if (digit_i == DIGIT_ZERO) begin
        digit_o = DIGIT_MAX;
        cout_o  = 1'b1;
      end else if (digit_i > DIGIT_MAX) begin
        digit_o = DIGIT_MAX;
        cout_o  = 1'b0;
      end else begin
        digit_o = digit_i - DIGIT_ONE;
        cout_o  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bcd_counter_ctrl.sv
// Up/down BCD event counter with clear/load and a rate-limited display refresh trigger.
module bcd_counter_ctrl
  import bcd_counter_ctrl_pkg::*;
#(
  parameter int DIGITS         = 6,
  parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      count_in,
  input  logic                      dir,
  input  logic                      clear,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_val,
  output logic [DIGIT_W*DIGITS-1:0] cnt_out,
  output logic                      trigger,
  output logic                      wrap
);

  localparam int CNT_W   = DIGIT_W * DIGITS;
  localparam int TIMER_W = $clog2(REFRESH_CYCLES);

  localparam logic [TIMER_W-1:0] TIMER_MAX  = TIMER_W'(REFRESH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ZERO = {TIMER_W{1'b0}};
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};

  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic               s3_q, s3_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               dirty_q, dirty_d;
  logic               trigger_q, trigger_d;
  logic               wrap_q, wrap_d;

  logic               event_s;
  logic               update_s;
  logic [CNT_W-1:0]   load_clean_s;
  logic [CNT_W-1:0]   step_s;
  logic [DIGITS:0]    carry_s;

  // Digit 0 always steps on an event; higher digits step only on ripple.
  assign carry_s[0] = 1'b1;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    bcd_digit u_digit (
      .digit_i (cnt_q[gi*DIGIT_W +: DIGIT_W]),
      .up_i    (dir),
      .cin_i   (carry_s[gi]),
      .digit_o (step_s[gi*DIGIT_W +: DIGIT_W]),
      .cout_o  (carry_s[gi+1])
    );
  end

  // Load value with out-of-range digits forced to zero.
  always_comb begin
    load_clean_s = CNT_ZERO;
    for (int i = 0; i < DIGITS; i++) begin
      load_clean_s[i*DIGIT_W +: DIGIT_W] = sanitize_digit(load_val[i*DIGIT_W +: DIGIT_W]);
    end
  end

  // Next-state logic for synchronizer, count value, wrap flag and refresh scheduler.
  always_comb begin
    s1_d    = count_in;
    s2_d    = s1_q;
    s3_d    = s2_q;
    event_s = s2_q & ~s3_q;

    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clear) begin
      cnt_d  = CNT_ZERO;
      wrap_d = 1'b0;
    end else if (load) begin
      cnt_d  = load_clean_s;
      wrap_d = 1'b0;
    end else if (event_s) begin
      cnt_d  = step_s;
      wrap_d = carry_s[DIGITS];
    end else begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
    end

    update_s = clear | load | event_s;

    // An update landing in the trigger cycle keeps dirty set for the next refresh.
    if (trigger_q) begin
      timer_d = TIMER_ZERO;
      dirty_d = update_s;
    end else if (timer_q == TIMER_MAX) begin
      timer_d = TIMER_MAX;
      dirty_d = dirty_q | update_s;
    end else begin
      timer_d = timer_q + TIMER_ONE;
      dirty_d = dirty_q | update_s;
    end

    trigger_d = dirty_d & (timer_d == TIMER_MAX);
  end

  // State registers; reset drops any pending trigger and in-flight count edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      cnt_q     <= CNT_ZERO;
      timer_q   <= TIMER_ZERO;
      dirty_q   <= 1'b1;
      trigger_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      dirty_q   <= dirty_d;
      trigger_q <= trigger_d;
      wrap_q    <= wrap_d;
    end
  end

  assign cnt_out = cnt_q;
  assign trigger = trigger_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_counter_ctrl.sv
// Directed self-checking bench for bcd_counter_ctrl (6 digits, refresh 32).
module tb_bcd_counter_ctrl;

  localparam int R = 32;

  logic        clk;
  logic        reset;
  logic        count_in;
  logic        dir;
  logic        clear;
  logic        load;
  logic [23:0] load_val;
  logic [23:0] cnt_out;
  logic        trigger;
  logic        wrap;

  int vectors;
  int miscompares;

  bcd_counter_ctrl #(.DIGITS(6), .REFRESH_CYCLES(R)) dut (
    .clk      (clk),
    .reset    (reset),
    .count_in (count_in),
    .dir      (dir),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .cnt_out  (cnt_out),
    .trigger  (trigger),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int t;
    r = 24'h0;
    t = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    vectors++;
    if (cnt_out !== 24'h000000 || trigger !== 1'b0 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: cnt=%h trig=%b wrap=%b, want 000000/0/0", cnt_out, trigger, wrap);
    end
    reset = 1'b0;
    for (int k = 1; k <= 3*R; k++) begin
      tick(1);
      vectors++;
      if (trigger !== (k == R-1)) begin
        miscompares++;
        $display("FAIL first_trigger edge %0d: trigger=%b want %b", k, trigger, (k == R-1));
      end
    end
    vectors++;
    if (cnt_out !== 24'h000000) begin
      miscompares++;
      $display("FAIL idle_count: cnt=%h want 000000", cnt_out);
    end
  endtask

  task automatic test_count_up();
    logic [23:0] exp;
    dir = 1'b1;
    for (int p = 1; p <= 12; p++) begin
      count_in = 1'b1;
      tick(2);
      exp = to_bcd(p - 1);
      vectors++;
      if (cnt_out !== exp) begin
        miscompares++;
        $display("FAIL count_latency pulse %0d: cnt=%h want %h", p, cnt_out, exp);
      end
      tick(1);
      exp = to_bcd(p);
      vectors++;
      if (cnt_out !== exp) begin
        miscompares++;
        $display("FAIL count_update pulse %0d: cnt=%h want %h", p, cnt_out, exp);
      end
      tick(p % 4);
      count_in = 1'b0;
      tick(3);
      vectors++;
      if (cnt_out !== exp) begin
        miscompares++;
        $display("FAIL count_hold pulse %0d: cnt=%h want %h", p, cnt_out, exp);
      end
    end
  endtask

  task automatic test_wrap();
    load_val = 24'h999999;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    vectors++;
    if (cnt_out !== 24'h999999 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL load_999999: cnt=%h wrap=%b want 999999/0", cnt_out, wrap);
    end
    dir = 1'b1;
    count_in = 1'b1;
    tick(3);
    vectors++;
    if (cnt_out !== 24'h000000 || wrap !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_up: cnt=%h wrap=%b want 000000/1", cnt_out, wrap);
    end
    tick(1);
    vectors++;
    if (wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_up_width: wrap=%b want 0", wrap);
    end
    count_in = 1'b0;
    tick(3);
    dir = 1'b0;
    count_in = 1'b1;
    tick(3);
    vectors++;
    if (cnt_out !== 24'h999999 || wrap !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_down: cnt=%h wrap=%b want 999999/1", cnt_out, wrap);
    end
    tick(1);
    vectors++;
    if (wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_down_width: wrap=%b want 0", wrap);
    end
    count_in = 1'b0;
    tick(3);
    load_val = 24'h001000;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    count_in = 1'b1;
    tick(3);
    vectors++;
    if (cnt_out !== 24'h000999 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL borrow_ripple: cnt=%h wrap=%b want 000999/0", cnt_out, wrap);
    end
    count_in = 1'b0;
    tick(3);
  endtask

  task automatic test_clear_load();
    load_val = 24'h00A95F;
    clear = 1'b1;
    load = 1'b1;
    tick(1);
    clear = 1'b0;
    load = 1'b0;
    vectors++;
    if (cnt_out !== 24'h000000) begin
      miscompares++;
      $display("FAIL clear_over_load: cnt=%h want 000000", cnt_out);
    end
    load = 1'b1;
    tick(1);
    load = 1'b0;
    vectors++;
    if (cnt_out !== 24'h000950) begin
      miscompares++;
      $display("FAIL load_sanitize: cnt=%h want 000950", cnt_out);
    end
    // load lands in the count event cycle and wins
    dir = 1'b1;
    count_in = 1'b1;
    tick(2);
    load_val = 24'h000777;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    vectors++;
    if (cnt_out !== 24'h000777) begin
      miscompares++;
      $display("FAIL load_over_count: cnt=%h want 000777", cnt_out);
    end
    count_in = 1'b0;
    tick(3);
    count_in = 1'b1;
    tick(2);
    load_val = 24'h000555;
    clear = 1'b1;
    load = 1'b1;
    tick(1);
    clear = 1'b0;
    load = 1'b0;
    vectors++;
    if (cnt_out !== 24'h000000) begin
      miscompares++;
      $display("FAIL clear_over_count: cnt=%h want 000000", cnt_out);
    end
    count_in = 1'b0;
    tick(3);
  endtask

  task automatic test_trigger_collision();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    dir = 1'b1;
    tick(R - 3);
    count_in = 1'b1;
    tick(1);
    vectors++;
    if (trigger !== 1'b0) begin
      miscompares++;
      $display("FAIL collide_pre: trigger=%b want 0", trigger);
    end
    tick(1);
    vectors++;
    if (trigger !== 1'b1 || cnt_out !== 24'h000000) begin
      miscompares++;
      $display("FAIL collide_trigger: trig=%b cnt=%h want 1/000000", trigger, cnt_out);
    end
    tick(1);
    vectors++;
    if (trigger !== 1'b0 || cnt_out !== 24'h000001) begin
      miscompares++;
      $display("FAIL collide_update: trig=%b cnt=%h want 0/000001", trigger, cnt_out);
    end
    count_in = 1'b0;
    for (int k = R + 1; k <= 2*R + 2; k++) begin
      tick(1);
      vectors++;
      if (trigger !== (k == 2*R - 1)) begin
        miscompares++;
        $display("FAIL second_trigger edge %0d: trigger=%b want %b", k, trigger, (k == 2*R - 1));
      end
    end
    vectors++;
    if (cnt_out !== 24'h000001) begin
      miscompares++;
      $display("FAIL collide_value: cnt=%h want 000001", cnt_out);
    end
  endtask

  task automatic test_reset_midop();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    load_val = 24'h000123;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    vectors++;
    if (cnt_out !== 24'h000123) begin
      miscompares++;
      $display("FAIL midop_load: cnt=%h want 000123", cnt_out);
    end
    tick(18);
    count_in = 1'b1;
    tick(1);
    vectors++;
    if (trigger !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_pre: trigger=%b want 0", trigger);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (cnt_out !== 24'h000000 || trigger !== 1'b0 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_async: cnt=%h trig=%b wrap=%b want 000000/0/0", cnt_out, trigger, wrap);
    end
    count_in = 1'b0;
    tick(2);
    reset = 1'b0;
    for (int k = 1; k <= 2*R; k++) begin
      tick(1);
      vectors++;
      if (trigger !== (k == R-1) || cnt_out !== 24'h000000) begin
        miscompares++;
        $display("FAIL midop_release edge %0d: trig=%b cnt=%h want %b/000000", k, trigger, cnt_out, (k == R-1));
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    count_in    = 1'b0;
    dir         = 1'b1;
    clear       = 1'b0;
    load        = 1'b0;
    load_val    = 24'h000000;
    #2;
    test_reset();
    test_count_up();
    test_wrap();
    test_clear_load();
    test_trigger_collision();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_counter_ctrl.md
BCD_COUNTER_CTRL -- requirements
Module: bcd_counter_ctrl

Interface
REQ-001 Parameter DIGITS, default 6, number of BCD digits.
REQ-002 Parameter REFRESH_CYCLES, default 32, minimum clk cycles between trigger pulses; SHALL be >= 26.
REQ-003 clk  input  1  system clock, rising-edge active.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 count_in  input  1  external count pulse, asynchronous to clk.
REQ-006 dir  input  1  count direction: 1 = up, 0 = down; sampled on the count event cycle.
REQ-007 clear  input  1  synchronous clear request, level.
REQ-008 load  input  1  synchronous load request, level.
REQ-009 load_val  input  4*DIGITS  BCD load value; digit 0 in bits [3:0].
REQ-010 cnt_out  output  4*DIGITS  current BCD count; digit 0 in bits [3:0].
REQ-011 trigger  output  1  one-cycle pulse that starts a downstream decode/output cycle on the current cnt_out.
REQ-012 wrap  output  1  one-cycle pulse on 99..9->0 (up) or 0->99..9 (down).

Function
REQ-013 count_in SHALL pass through a 3-flop chain s1->s2->s3; count event = s2 & ~s3.
REQ-014 A count_in rising edge first sampled at edge N SHALL update cnt_out at edge N+2; one event per rising edge, regardless of pulse width.
REQ-015 Priority per cycle: clear > load > count event; lower-priority requests in that cycle are discarded.
REQ-016 clear SHALL set cnt_out to all zeros on the next edge.
REQ-017 load SHALL copy load_val on the next edge; any digit > 9 is stored as 0, other digits unaffected.
REQ-018 Up count: digit-wise BCD increment, carry ripples 9->0 into the next digit within the same cycle.
REQ-019 Down count: digit-wise BCD decrement, borrow ripples 0->9 into the next digit within the same cycle.
REQ-020 Full-scale wrap (all 9 up, or all 0 down) SHALL wrap to all 0 / all 9 and assert wrap for exactly the cycle after the update edge.
REQ-021 A dirty flag SHALL be set by every clear, load or count event, whether or not the value changes.
REQ-022 A refresh timer SHALL increment each cycle, saturating at REFRESH_CYCLES-1.
REQ-023 trigger SHALL assert (registered, one cycle) when dirty = 1 and timer = REFRESH_CYCLES-1; in that cycle timer returns to 0 and dirty clears.
REQ-024 A clear/load/count event coinciding with the trigger cycle SHALL leave dirty = 1; the new value is reported by the next trigger.
REQ-025 cnt_out SHALL be stable during the trigger cycle (trigger and update never refer to different values in the same cycle).
REQ-026 No trigger SHALL occur while dirty = 0; timer stays saturated.

Reset
REQ-027 reset SHALL force cnt_out = 0, trigger = 0, wrap = 0, s1/s2/s3 = 0, timer = 0, dirty = 1.
REQ-028 First trigger after reset release SHALL occur REFRESH_CYCLES-1 edges after release with no other stimulus.
REQ-029 reset asserted mid-operation SHALL abort any pending trigger immediately; a count_in edge in flight is lost.

Structure
REQ-030 Shared package SHALL hold BCD digit width (4), max digit value (9) and REFRESH_CYCLES default.
REQ-031 One sub-module bcd_digit SHALL implement a single-digit increment/decrement with carry/borrow in and out; DIGITS instances chained.
REQ-032 All state SHALL be in the clk domain except the first synchronizer flop input.

Verification
REQ-033 Reset release, no stimulus -> single trigger after REFRESH_CYCLES-1 edges, cnt_out = 000000, no further triggers.
REQ-034 dir=1, 12 count_in pulses from 000000 -> cnt_out = 000012; each update exactly 2 edges after first sampled high.
REQ-035 load_val = 999999 then one up event -> cnt_out = 000000, wrap one cycle; dir=0 one event -> 999999, wrap one cycle.
REQ-036 load_val = 0x00A95F in same cycle as clear -> cnt_out = 000000; load alone -> cnt_out = 000950.
REQ-037 Count event landing in the trigger cycle -> that trigger pulses, dirty stays set, second trigger exactly REFRESH_CYCLES cycles later with the incremented value.
REQ-038 reset pulsed while timer = 20 and dirty = 1 -> no trigger until REFRESH_CYCLES-1 edges after release, cnt_out = 0.
